// File: rtl/game_timer_driver.sv
// game_timer_driver: paces a downstream count-to-100 counter and counts game seconds down to expiry.
// Ports: clk (rising edge), rst (async, active-low), start/pause/stop/load controls, load_val seconds to load,
//        timeout_in (pulse from counter), increment (strobe to counter), cnt_clr_n (active-low counter clear),
//        seconds (remaining), running (in RUN), done (expiry pulse), warn (low-time warning).
// Optional: define TIMER_WARN_EN to enable the warn threshold logic; otherwise warn is tied low.
module game_timer_driver #(
    parameter int DIV       = 500000,
    parameter int START_SEC = 60,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       timeout_in,
    output logic       increment,
    output logic       cnt_clr_n,
    output logic [6:0] seconds,
    output logic       running,
    output logic       done,
    output logic       warn
);
    localparam int W = $clog2(DIV);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [6:0] START = 7'(START_SEC);

    logic [1:0]   state, state_n;
    logic [W-1:0] div_cnt, div_n;
    logic [6:0]   seconds_n;
    logic         inc_n, clr_n_n, done_n, active, dec;

    assign active = state == RUN || state == PAUSE;
    // a timeout at zero is dropped so seconds can never wrap
    assign dec = active && timeout_in && seconds != 7'd0;

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        seconds_n = seconds;
        inc_n     = 1'b0;
        clr_n_n   = 1'b1;
        done_n    = 1'b0;
        if (stop) begin
            state_n   = IDLE;
            seconds_n = START;
            div_n     = '0;
        end else if (load && !active) begin
            state_n   = IDLE;
            seconds_n = load_val > 7'd99 ? 7'd99 : load_val;
        end else if (state == IDLE) begin
            if (start && seconds == 7'd0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else if (start) begin
                state_n = RUN;
                div_n   = '0;
                clr_n_n = 1'b0;
            end
        end else if (active) begin
            if (dec)
                seconds_n = seconds - 7'd1;
            // expiry beats pause/resume; the prescaler only advances on plain RUN cycles
            if (dec && seconds == 7'd1) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else if (state == RUN && pause)
                state_n = PAUSE;
            else if (state == PAUSE)
                state_n = start && !pause ? RUN : PAUSE;
            else begin
                inc_n = div_cnt == LAST;
                div_n = div_cnt == LAST ? '0 : div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            seconds   <= START;
            increment <= 1'b0;
            cnt_clr_n <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            seconds   <= seconds_n;
            increment <= inc_n;
            cnt_clr_n <= clr_n_n;
            running   <= state_n == RUN;
            done      <= done_n;
        end
    end

`ifdef TIMER_WARN_EN
    localparam logic [6:0] WARN = 7'(WARN_SEC);

    // sampled from the current registers, so warn trails a seconds change by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            warn <= 1'b0;
        else
            warn <= active && seconds != 7'd0 && seconds <= WARN;
    end
`else
    assign warn = 1'b0;
`endif
endmodule

// File: tb/tb_game_timer_driver.sv
// tb_game_timer_driver: randomized and directed checks of game_timer_driver against a behavioural model.
module tb_game_timer_driver;
    localparam int DIV = 4, START_SEC = 3, WARN_SEC = 2;

    logic clk = 0, rst = 0, start = 0, pause = 0, stop = 0, load = 0, timeout_in = 0;
    logic [6:0] load_val = 0;
    logic increment, cnt_clr_n, running, done, warn;
    logic [6:0] seconds;

    int checks = 0, errors = 0;
    int m_st, m_sec, m_ph;
    logic m_inc, m_clr, m_done, m_warn;
    int dcnt = 0, rc = 0, last_gap = 0, inc_total = 0, done_total = 0;
    logic pend = 0, run_now = 0;

    always #5 clk = ~clk;

    game_timer_driver #(.DIV(DIV), .START_SEC(START_SEC), .WARN_SEC(WARN_SEC)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .load(load),
        .load_val(load_val), .timeout_in(timeout_in), .increment(increment), .cnt_clr_n(cnt_clr_n),
        .seconds(seconds), .running(running), .done(done), .warn(warn)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // states: 0 idle, 1 run, 2 pause, 3 done; m_ph counts prescaler RUN clocks since the last strobe
    task model_reset;
        m_st = 0; m_sec = START_SEC; m_ph = 0;
        m_inc = 0; m_clr = 1; m_done = 0; m_warn = 0;
    endtask

    task model_step;
        logic act, expire;
        if (!rst) model_reset();
        else begin
            act = m_st == 1 || m_st == 2;
`ifdef TIMER_WARN_EN
            m_warn = act && m_sec >= 1 && m_sec <= WARN_SEC;
`else
            m_warn = 0;
`endif
            m_inc = 0; m_clr = 1; m_done = 0;
            if (stop) begin
                m_st = 0; m_sec = START_SEC; m_ph = 0;
            end else if (load && !act) begin
                m_st = 0;
                m_sec = load_val > 99 ? 99 : int'(load_val);
            end else if (m_st == 0) begin
                if (start) begin
                    if (m_sec == 0) begin m_st = 3; m_done = 1; end
                    else begin m_st = 1; m_ph = 0; m_clr = 0; end
                end
            end else if (act) begin
                expire = timeout_in && m_sec == 1;
                if (timeout_in && m_sec > 0) m_sec = m_sec - 1;
                if (expire) begin m_st = 3; m_done = 1; end
                else if (m_st == 1 && pause) m_st = 2;
                else if (m_st == 2) begin if (start && !pause) m_st = 1; end
                else begin
                    m_ph = m_ph + 1;
                    if (m_ph == DIV) begin m_ph = 0; m_inc = 1; end
                end
            end
        end
    endtask

    task compare;
        chk("increment", increment, m_inc);
        chk("cnt_clr_n", cnt_clr_n, m_clr);
        chk("seconds", seconds, m_sec);
        chk("running", running, m_st == 1);
        chk("done", done, m_done);
        chk("warn", warn, m_warn);
    endtask

    // one clock: model and DUT advance on the edge, outputs compared at the falling edge,
    // then the downstream counter model schedules timeout_in one cycle after its 100th strobe
    task tick;
        if (run_now && !pause) rc++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (increment) begin last_gap = rc; rc = 0; inc_total++; end
        if (done) done_total++;
        run_now = running;
        timeout_in = pend;
        pend = 0;
        if (!cnt_clr_n) dcnt = 0;
        else if (increment) begin
            dcnt++;
            if (dcnt == 100) begin dcnt = 0; pend = 1; end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare();
        chk("rst_seconds", seconds, 3);
        chk("rst_clr", cnt_clr_n, 1);
        chk("rst_running", running, 0);
        rst = 1;

        // full countdown from 3 s
        start = 1; tick(); start = 0;
        chk("start_clr", cnt_clr_n, 0);
        chk("start_running", running, 1);
        inc_total = 0; done_total = 0;
        for (int i = 0; i < 3000 && done_total == 0; i++) tick();
        chk("b_done_count", done_total, 1);
        chk("b_increments", inc_total, 300);
        chk("b_seconds", seconds, 0);
        chk("b_running", running, 0);
        tick();
        chk("b_done_width", done, 0);

        // DONE / IDLE handling of load and stray timeouts
        timeout_in = 1; tick();
        chk("done_timeout_ignored", seconds, 0);
        load_val = 120; load = 1; tick(); load = 0;
        chk("load_clamp", seconds, 99);
        chk("load_idle", running, 0);
        timeout_in = 1; tick();
        chk("idle_timeout_ignored", seconds, 99);
        load_val = 0; load = 1; tick(); load = 0;
        start = 1; tick(); start = 0;
        chk("zero_start_done", done, 1);
        chk("zero_start_inc", increment, 0);
        chk("zero_start_running", running, 0);
        tick();
        chk("zero_start_done_once", done, 0);

        // pause freezes the prescaler; resume continues the interrupted interval
        stop = 1; tick(); stop = 0;
        chk("stop_reload", seconds, 3);
        start = 1; tick(); start = 0;
        repeat (10) tick();
        pause = 1; inc_total = 0;
        repeat (50) tick();
        chk("pause_no_inc", inc_total, 0);
        pause = 0; start = 1; tick(); start = 0;
        for (int i = 0; i < 20 && inc_total == 0; i++) tick();
        chk("resume_inc_seen", inc_total, 1);
        chk("resume_gap", last_gap, 4);

        // stop dominates start and pause
        stop = 1; start = 1; pause = 1; tick(); stop = 0; start = 0; pause = 0;
        chk("stop_prio_seconds", seconds, 3);
        chk("stop_prio_running", running, 0);
        chk("stop_prio_inc", increment, 0);

        // asynchronous reset mid-run
        start = 1; tick(); start = 0;
        repeat (7) tick();
        #2 rst = 0;
        model_reset();
        pend = 0; dcnt = 0; timeout_in = 0;
        #1;
        chk("arst_inc", increment, 0);
        chk("arst_clr", cnt_clr_n, 1);
        chk("arst_seconds", seconds, 3);
        chk("arst_running", running, 0);
        chk("arst_done", done, 0);
        chk("arst_warn", warn, 0);
        tick();
        rst = 1;

        // timeout coincident with pause, warning window, expiry from PAUSE
        start = 1; tick(); start = 0;
        repeat (3) tick();
        timeout_in = 1; tick();
        chk("g_sec2", seconds, 2);
        tick();
`ifdef TIMER_WARN_EN
        chk("warn_rise", warn, 1);
`else
        chk("warn_off", warn, 0);
`endif
        timeout_in = 1; pause = 1; tick();
        chk("to_pause_sec", seconds, 1);
        chk("to_pause_state", running, 0);
        repeat (5) tick();
`ifdef TIMER_WARN_EN
        chk("warn_in_pause", warn, 1);
`else
        chk("warn_off_pause", warn, 0);
`endif
        timeout_in = 1; tick();
        chk("pause_expire", done, 1);
        tick();
        chk("warn_fall", warn, 0);
        pause = 0;

        // randomized traffic checked cycle by cycle against the model
        stop = 1; tick(); stop = 0;
        for (int i = 0; i < 5000; i++) begin
            start = $urandom_range(0, 9) == 0;
            pause = $urandom_range(0, 19) == 0;
            stop = $urandom_range(0, 299) == 0;
            load = $urandom_range(0, 99) == 0;
            load_val = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 199) == 0) timeout_in = 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
